wca_write_multibyte_reg: RTL and testbench
==========================================

Name: wca_write_multibyte_reg

Overview:
- Parametrised write register on the 8-bit rbus: assembles NBYTES sequential byte writes into an internal shadow, then commits all bytes to `out` atomically.
- Generalises the fixed 4-byte write register with:
  - configurable width and byte order;
  - an atomic commit with a one-cycle update pulse;
  - optional byte-sequential readback of the committed value;
  - per-bit self-clearing (pulse) fields.
- Sits beside the other rbus register blocks and drives control words into datapath modules.

Parameters:
- MY_ADDR, 0: rbus address decoded against rbusCtrl[11:4].
- NBYTES, 4: register width in bytes, legal range 1..8.
- MSB_FIRST, 0: 0 means the first byte lands in out[7:0]; 1 means the first byte lands in the most significant byte.
- READBACK, 1: 1 enables tri-state readback on rbusData; 0 means rbusData is never driven.
- RESET_VAL, 0: value of `out` after reset; 8*NBYTES bits.
- PULSE_MASK, 0: bits set here return to RESET_VAL one clock after each commit; 8*NBYTES bits.

Ports:
- clock  input  1  rbus clock; same net as rbusCtrl[0]. Every flop uses its rising edge.
- reset  input  1  asynchronous, active-low reset.
- rbusCtrl  input  12  {addr[7:0], readEnable, writeEnable, dataStrobe, clkbus}. Bit 0 is ignored in favour of `clock`.
- rbusData  inout  8  tri-state bus data.
- out  output  8*NBYTES  committed register value.
- update  output  1  one-clock pulse after each commit.

Behaviour:
- Reset (async assert, low):
  - out = RESET_VAL, update = 0.
  - Shadow cleared to RESET_VAL; wr_idx = 0, rd_idx = 0.
  - rbusData released to Z.
- Decode:
  - addrValid = (rbusCtrl[11:4] == MY_ADDR).
  - wr_stb = addrValid & writeEnable & dataStrobe.
  - rd_stb = addrValid & readEnable & dataStrobe.
- Byte lane mapping: lane(i) = i if MSB_FIRST = 0, else NBYTES-1-i.
- Write sequencer: wr_idx counts 0..NBYTES-1, width clog2(NBYTES), minimum 1 bit.
  - On a clock with wr_stb and wr_idx < NBYTES-1:
    - shadow lane(wr_idx) <= rbusData;
    - wr_idx increments.
  - On a clock with wr_stb and wr_idx == NBYTES-1 (commit):
    - out <= shadow with lane(wr_idx) replaced by rbusData, all bytes updated on the same edge;
    - shadow takes the same value;
    - wr_idx <= 0;
    - update = 1 for exactly the following clock.
  - NBYTES = 1: every wr_stb is a commit.
- Abort: any clock with addrValid = 0 resets wr_idx and rd_idx to 0.
  - Partial shadow bytes stay captured but never reach out until a complete NBYTES sequence finishes.
  - out is unchanged by an abort.
- Pulse fields: on the clock after a commit, out <= (out & ~PULSE_MASK) | (RESET_VAL & PULSE_MASK).
  - Non-masked bits hold.
  - A new commit on that same clock takes priority: the new value loads and the clear happens one clock later.
- Readback (READBACK = 1):
  - rbusData = byte lane(rd_idx) of out while addrValid & readEnable & ~writeEnable; otherwise Z.
  - rd_idx increments on rd_stb and wraps NBYTES-1 -> 0.
  - Readback shows committed out only, never the shadow.
- Simultaneous readEnable & writeEnable:
  - write wins;
  - bus stays Z;
  - rd_idx holds.
- Reset asserted mid-sequence: immediate return to the reset state; the sequence restarts at byte 0 after release.
- Registers hold their value whenever no strobe is present, and also while the address is valid with dataStrobe low.

Test Plan:
- Reset, NBYTES = 4, RESET_VAL = 0x12345678 -> out = 0x12345678, update = 0, rbusData = Z.
- MSB_FIRST = 0; write 0x11, 0x22, 0x33, 0x44 at MY_ADDR -> out stays 0x12345678 through byte 3, becomes 0x44332211 on the byte-4 edge, and update pulses exactly one clock.
- MSB_FIRST = 1, same bytes -> out = 0x11223344.
- Write 0xAA, 0xBB, then drop the address for one clock, then write 0x01, 0x02, 0x03, 0x04 -> no commit after the abort; final out = 0x04030201.
- PULSE_MASK = 0x00000001, RESET_VAL = 0; commit 0x80000001 -> out = 0x80000001 for one clock, then 0x80000000.
- Readback after commit 0xDEADBEEF, four read strobes -> rbusData = 0xEF, 0xBE, 0xAD, 0xDE, then wraps to 0xEF.
- Reset pulsed low after 2 bytes -> out = RESET_VAL; a fresh 4-byte write then commits correctly.

Source files
------------

// File: rtl/wca_write_multibyte_reg.sv
`default_nettype none
// ============================================================================
// Module      : wca_write_multibyte_reg
// Description : rbus write register that assembles NBYTES byte writes in a
//               shadow and commits them to `out` atomically, with an update
//               pulse, optional readback and self-clearing pulse bits.
// Revision    : 1.0 - initial release
// ============================================================================
module wca_write_multibyte_reg #(
  parameter logic [7:0]            MY_ADDR    = 8'h00,
  parameter int                    NBYTES     = 4,
  parameter bit                    MSB_FIRST  = 1'b0,
  parameter bit                    READBACK   = 1'b1,
  parameter logic [8*NBYTES-1:0]   RESET_VAL  = '0,
  parameter logic [8*NBYTES-1:0]   PULSE_MASK = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [11:0]           rbusCtrl,
  inout  wire  [7:0]            rbusData,
  output logic [8*NBYTES-1:0]   out,
  output logic                  update
);

  localparam int              W        = 8 * NBYTES;
  localparam int              IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [W-1:0]     r_shadow;
  logic [W-1:0]     r_out;
  logic             r_update;
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] r_rd_idx;

  logic             w_addr_valid;
  logic             w_rd_en;
  logic             w_wr_en;
  logic             w_strobe;
  logic             w_wr_stb;
  logic             w_rd_stb;
  logic             w_commit;
  logic [W-1:0]     w_merged;
  logic [7:0]       w_rd_byte;
  logic             w_unused_clkbus;

  // Bit 0 of the control bus carries the bus clock; the dedicated clock pin is used instead.
  assign w_unused_clkbus = rbusCtrl[0];

  assign w_addr_valid = (rbusCtrl[11:4] == MY_ADDR);
  assign w_rd_en      = rbusCtrl[3];
  assign w_wr_en      = rbusCtrl[2];
  assign w_strobe     = rbusCtrl[1];
  assign w_wr_stb     = w_addr_valid & w_wr_en & w_strobe;
  assign w_rd_stb     = w_addr_valid & w_rd_en & w_strobe;
  assign w_commit     = w_wr_stb & (r_wr_idx == LAST_IDX);

  function automatic int lane(input int i);
    return MSB_FIRST ? (NBYTES - 1 - i) : i;
  endfunction

  always_comb begin
    w_merged  = r_shadow;
    w_rd_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (r_wr_idx == IDX_W'(i)) w_merged[8*lane(i) +: 8] = rbusData;
      if (r_rd_idx == IDX_W'(i)) w_rd_byte = r_out[8*lane(i) +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shadow <= RESET_VAL;
      r_out    <= RESET_VAL;
      r_update <= 1'b0;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
    end else begin
      r_update <= w_commit;
      // A commit on the clock after a previous commit wins over the pulse clear.
      if (w_commit) begin
        r_out    <= w_merged;
        r_shadow <= w_merged;
      end else begin
        if (r_update) r_out <= (r_out & ~PULSE_MASK) | (RESET_VAL & PULSE_MASK);
        if (w_wr_stb) r_shadow <= w_merged;
      end

      if (!w_addr_valid) begin
        r_wr_idx <= '0;
        r_rd_idx <= '0;
      end else begin
        if (w_wr_stb) r_wr_idx <= w_commit ? '0 : r_wr_idx + IDX_W'(1);
        if (w_rd_stb && !w_wr_en)
          r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + IDX_W'(1);
      end
    end
  end

  generate
    if (READBACK) begin : g_readback
      assign rbusData = (w_addr_valid && w_rd_en && !w_wr_en) ? w_rd_byte : 8'hzz;
    end else begin : g_no_readback
      assign rbusData = 8'hzz;
    end
  endgenerate

  assign out    = r_out;
  assign update = r_update;

endmodule
`default_nettype wire

// File: tb/tb_wca_write_multibyte_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_wca_write_multibyte_reg
// Description : Vector-table bench for wca_write_multibyte_reg over four
//               configurations sharing one rbus control stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wca_write_multibyte_reg;

  localparam logic [7:0] ADDR = 8'h5A;
  localparam int K_IDLE = 0, K_WR = 1, K_HOLD = 2, K_RD = 3, K_RW0 = 4, K_RW1 = 5, K_RST = 6;
  localparam logic [7:0] ZB = 8'hFF;  // undriven bus as seen through the pullups

  typedef struct {
    int          kind;
    logic [7:0]  din;
    logic [31:0] eA, eB, eC;
    logic [7:0]  eD;
    logic        eu;
    logic [7:0]  rA, rB, rC;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] ctrl = 12'h000;
  logic        tb_drv = 1'b0;
  logic [7:0]  tb_din = 8'h00;

  wire  [7:0]  busA, busB, busC, busD;
  logic [31:0] outA, outB, outC;
  logic [7:0]  outD;
  logic        updA, updB, updC, updD;

  assign busA = tb_drv ? tb_din : 8'hzz;
  assign busB = tb_drv ? tb_din : 8'hzz;
  assign busC = tb_drv ? tb_din : 8'hzz;
  assign busD = tb_drv ? tb_din : 8'hzz;
  pullup pu_a (busA);
  pullup pu_b (busB);
  pullup pu_c (busC);
  pullup pu_d (busD);

  always #5 clk = ~clk;

  wca_write_multibyte_reg #(.MY_ADDR(ADDR), .NBYTES(4), .MSB_FIRST(1'b0), .READBACK(1'b1),
    .RESET_VAL(32'h12345678), .PULSE_MASK(32'h0)) u_a (
    .clock(clk), .reset(rst_n), .rbusCtrl(ctrl), .rbusData(busA), .out(outA), .update(updA));
  wca_write_multibyte_reg #(.MY_ADDR(ADDR), .NBYTES(4), .MSB_FIRST(1'b1), .READBACK(1'b1),
    .RESET_VAL(32'h12345678), .PULSE_MASK(32'h0)) u_b (
    .clock(clk), .reset(rst_n), .rbusCtrl(ctrl), .rbusData(busB), .out(outB), .update(updB));
  wca_write_multibyte_reg #(.MY_ADDR(ADDR), .NBYTES(4), .MSB_FIRST(1'b0), .READBACK(1'b1),
    .RESET_VAL(32'h0), .PULSE_MASK(32'h00000001)) u_c (
    .clock(clk), .reset(rst_n), .rbusCtrl(ctrl), .rbusData(busC), .out(outC), .update(updC));
  wca_write_multibyte_reg #(.MY_ADDR(ADDR), .NBYTES(1), .MSB_FIRST(1'b0), .READBACK(1'b0),
    .RESET_VAL(8'hA5), .PULSE_MASK(8'h0F)) u_d (
    .clock(clk), .reset(rst_n), .rbusCtrl(ctrl), .rbusData(busD), .out(outD), .update(updD));

  int   checks = 0;
  int   failures = 0;
  vec_t vecs[64];
  int   nv = 0;

  task automatic chk(input string name, input int v, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, v, act, exp);
    end
  endtask

  task automatic add(input int k, input logic [7:0] d, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input logic [7:0] dd, input logic u,
                     input logic [7:0] ra, input logic [7:0] rb, input logic [7:0] rc);
    vecs[nv].kind = k;  vecs[nv].din = d;
    vecs[nv].eA = a;    vecs[nv].eB = b;  vecs[nv].eC = c;  vecs[nv].eD = dd;  vecs[nv].eu = u;
    vecs[nv].rA = ra;   vecs[nv].rB = rb; vecs[nv].rC = rc;
    nv++;
  endtask

  task automatic drive(input int k, input logic [7:0] d);
    rst_n  = (k != K_RST);
    tb_din = d;
    tb_drv = (k == K_WR) || (k == K_RW1);
    case (k)
      K_WR:    ctrl = {ADDR, 1'b0, 1'b1, 1'b1, 1'b0};
      K_HOLD:  ctrl = {ADDR, 1'b0, 1'b1, 1'b0, 1'b0};
      K_RD:    ctrl = {ADDR, 1'b1, 1'b0, 1'b1, 1'b0};
      K_RW0:   ctrl = {ADDR, 1'b1, 1'b1, 1'b0, 1'b0};
      K_RW1:   ctrl = {ADDR, 1'b1, 1'b1, 1'b1, 1'b0};
      default: ctrl = 12'h000;
    endcase
  endtask

  initial begin
    // kind     din    outA          outB          outC          outD   upd  rdA    rdB    rdC
    add(K_WR,   8'h11, 32'h12345678, 32'h12345678, 32'h00000000, 8'h11, 0, 0, 0, 0);
    add(K_WR,   8'h22, 32'h12345678, 32'h12345678, 32'h00000000, 8'h22, 0, 0, 0, 0);
    add(K_WR,   8'h33, 32'h12345678, 32'h12345678, 32'h00000000, 8'h33, 0, 0, 0, 0);
    add(K_WR,   8'h44, 32'h44332211, 32'h11223344, 32'h44332211, 8'h44, 1, 0, 0, 0);
    add(K_IDLE, 8'h00, 32'h44332211, 32'h11223344, 32'h44332210, 8'h45, 0, 0, 0, 0);
    // partial sequence, then abort
    add(K_WR,   8'hAA, 32'h44332211, 32'h11223344, 32'h44332210, 8'hAA, 0, 0, 0, 0);
    add(K_WR,   8'hBB, 32'h44332211, 32'h11223344, 32'h44332210, 8'hBB, 0, 0, 0, 0);
    add(K_IDLE, 8'h00, 32'h44332211, 32'h11223344, 32'h44332210, 8'hB5, 0, 0, 0, 0);
    add(K_WR,   8'h01, 32'h44332211, 32'h11223344, 32'h44332210, 8'h01, 0, 0, 0, 0);
    add(K_WR,   8'h02, 32'h44332211, 32'h11223344, 32'h44332210, 8'h02, 0, 0, 0, 0);
    add(K_WR,   8'h03, 32'h44332211, 32'h11223344, 32'h44332210, 8'h03, 0, 0, 0, 0);
    add(K_WR,   8'h04, 32'h04030201, 32'h01020304, 32'h04030201, 8'h04, 1, 0, 0, 0);
    add(K_IDLE, 8'h00, 32'h04030201, 32'h01020304, 32'h04030200, 8'h05, 0, 0, 0, 0);
    // pulse field: 0x80000001
    add(K_WR,   8'h01, 32'h04030201, 32'h01020304, 32'h04030200, 8'h01, 0, 0, 0, 0);
    add(K_WR,   8'h00, 32'h04030201, 32'h01020304, 32'h04030200, 8'h00, 0, 0, 0, 0);
    add(K_WR,   8'h00, 32'h04030201, 32'h01020304, 32'h04030200, 8'h00, 0, 0, 0, 0);
    add(K_WR,   8'h80, 32'h80000001, 32'h01000080, 32'h80000001, 8'h80, 1, 0, 0, 0);
    add(K_HOLD, 8'h55, 32'h80000001, 32'h01000080, 32'h80000000, 8'h85, 0, 0, 0, 0);
    // readback of 0xDEADBEEF
    add(K_WR,   8'hEF, 32'h80000001, 32'h01000080, 32'h80000000, 8'hEF, 0, 0, 0, 0);
    add(K_WR,   8'hBE, 32'h80000001, 32'h01000080, 32'h80000000, 8'hBE, 0, 0, 0, 0);
    add(K_WR,   8'hAD, 32'h80000001, 32'h01000080, 32'h80000000, 8'hAD, 0, 0, 0, 0);
    add(K_WR,   8'hDE, 32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEF, 8'hDE, 1, 0, 0, 0);
    add(K_IDLE, 8'h00, 32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEE, 8'hD5, 0, 0, 0, 0);
    add(K_RD,   8'h00, 32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEE, 8'hD5, 0, 8'hEF, 8'hEF, 8'hEE);
    add(K_RD,   8'h00, 32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEE, 8'hD5, 0, 8'hBE, 8'hBE, 8'hBE);
    add(K_RD,   8'h00, 32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEE, 8'hD5, 0, 8'hAD, 8'hAD, 8'hAD);
    add(K_RD,   8'h00, 32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEE, 8'hD5, 0, 8'hDE, 8'hDE, 8'hDE);
    add(K_RD,   8'h00, 32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEE, 8'hD5, 0, 8'hEF, 8'hEF, 8'hEE);
    // read+write together: bus stays Z, write wins, read index holds
    add(K_RW0,  8'h00, 32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEE, 8'hD5, 0, 0, 0, 0);
    add(K_RW1,  8'h77, 32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEE, 8'h77, 0, 0, 0, 0);
    add(K_RD,   8'h00, 32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEE, 8'h75, 0, 8'hBE, 8'hBE, 8'hBE);
    // reset mid-sequence, then a fresh full write
    add(K_IDLE, 8'h00, 32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEE, 8'h75, 0, 0, 0, 0);
    add(K_WR,   8'h01, 32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEE, 8'h01, 0, 0, 0, 0);
    add(K_WR,   8'h02, 32'hDEADBEEF, 32'hEFBEADDE, 32'hDEADBEEE, 8'h02, 0, 0, 0, 0);
    add(K_RST,  8'h00, 32'h12345678, 32'h12345678, 32'h00000000, 8'hA5, 0, 0, 0, 0);
    add(K_WR,   8'h10, 32'h12345678, 32'h12345678, 32'h00000000, 8'h10, 0, 0, 0, 0);
    add(K_WR,   8'h20, 32'h12345678, 32'h12345678, 32'h00000000, 8'h20, 0, 0, 0, 0);
    add(K_WR,   8'h30, 32'h12345678, 32'h12345678, 32'h00000000, 8'h30, 0, 0, 0, 0);
    add(K_WR,   8'h40, 32'h40302010, 32'h10203040, 32'h40302010, 8'h40, 1, 0, 0, 0);
    add(K_IDLE, 8'h00, 32'h40302010, 32'h10203040, 32'h40302010, 8'h45, 0, 0, 0, 0);

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_outA", -1, 64'(outA), 64'h12345678);
    chk("reset_outB", -1, 64'(outB), 64'h12345678);
    chk("reset_outC", -1, 64'(outC), 64'h0);
    chk("reset_outD", -1, 64'(outD), 64'hA5);
    chk("reset_upd",  -1, 64'({updA, updB, updC, updD}), 64'h0);
    chk("reset_busA", -1, 64'(busA), 64'(ZB));

    for (int v = 0; v < nv; v++) begin
      drive(vecs[v].kind, vecs[v].din);
      #1;
      if (vecs[v].kind == K_RD) begin
        chk("rd_busA", v, 64'(busA), 64'(vecs[v].rA));
        chk("rd_busB", v, 64'(busB), 64'(vecs[v].rB));
        chk("rd_busC", v, 64'(busC), 64'(vecs[v].rC));
        chk("rd_busD_z", v, 64'(busD), 64'(ZB));
      end else if (vecs[v].kind != K_WR && vecs[v].kind != K_RW1) begin
        chk("bus_z", v, 64'({busA, busB, busC, busD}), {32'h0, ZB, ZB, ZB, ZB});
      end
      if (vecs[v].kind == K_RST) begin
        chk("async_rst_outA", v, 64'(outA), 64'(vecs[v].eA));
        chk("async_rst_outD", v, 64'(outD), 64'(vecs[v].eD));
      end
      @(posedge clk);
      #2;
      chk("outA", v, 64'(outA), 64'(vecs[v].eA));
      chk("outB", v, 64'(outB), 64'(vecs[v].eB));
      chk("outC", v, 64'(outC), 64'(vecs[v].eC));
      chk("outD", v, 64'(outD), 64'(vecs[v].eD));
      chk("updateA", v, 64'(updA), 64'(vecs[v].eu));
      chk("updateC", v, 64'(updC), 64'(vecs[v].eu));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
